// File: rtl/aes_vector_gen.sv
// rtl/aes_vector_gen.sv - AES known-answer / stimulus vector generator
// Streams VarKey, VarText, LFSR-random or fixed vectors with per-vector repeat over valid/ready.
module aes_vector_gen #(
   parameter int           KEY_SIZE  = 128,
   parameter int           REPEAT_W  = 8,
   parameter int           CNT_W     = 16,
   parameter logic [127:0] LFSR_SEED = 128'h1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [1:0]          mode,
   input  logic [REPEAT_W-1:0] repeat_cnt,
   input  logic [CNT_W-1:0]    num_vec,
   input  logic [127:0]        fixed_text,
   input  logic [KEY_SIZE-1:0] fixed_key,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [127:0]        plainText,
   output logic [KEY_SIZE-1:0] cypher_key,
   output logic [CNT_W-1:0]    vec_idx,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   typedef struct packed {
      logic [127:0]        text;
      logic [KEY_SIZE-1:0] key;
   } vec_t;

   state_t              state, state_n;
   logic [1:0]          mode_r;
   logic [REPEAT_W-1:0] rep_max, rep, rep_n;
   logic [CNT_W-1:0]    cnt_r, start_cnt, idx_n;
   logic [127:0]        ftext_r, lfsr, lfsr_n, lfsr_adv;
   logic [KEY_SIZE-1:0] fkey_r;
   logic                valid_n, busy_n, done_n, last;
   vec_t                vec_n;

   function automatic vec_t gen_vec(input logic [1:0]          m,
                                    input logic [CNT_W-1:0]    i,
                                    input logic [127:0]        s,
                                    input logic [127:0]        ft,
                                    input logic [KEY_SIZE-1:0] fk);
      vec_t v;
      v = '0;
      case (m)
         2'd0:    v.key  = ~({KEY_SIZE{1'b1}} >> (32'(i) + 32'd1));
         2'd1:    v.text = ~({128{1'b1}} >> (32'(i) + 32'd1));
         2'd2:    begin v.text = s;  v.key = fk; end
         default: begin v.text = ft; v.key = fk; end
      endcase
      return v;
   endfunction

   function automatic logic [127:0] lfsr_step(input logic [127:0] s);
      return {s[126:0], s[127] ^ s[126] ^ s[125] ^ s[120]};
   endfunction

   always_comb begin
      case (mode)
         2'd0:    start_cnt = CNT_W'(KEY_SIZE);
         2'd1:    start_cnt = CNT_W'(128);
         default: start_cnt = num_vec;
      endcase
   end

   // LFSR only moves in Random mode, and only when a new vector is fetched
   assign lfsr_adv = (mode_r == 2'd2) ? lfsr_step(lfsr) : lfsr;
   assign last     = (vec_idx == cnt_r - 1'b1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_r  <= '0;
         rep_max <= '0;
         cnt_r   <= '0;
         ftext_r <= '0;
         fkey_r  <= '0;
      end else if (state == IDLE && start) begin
         mode_r  <= mode;
         rep_max <= repeat_cnt;
         cnt_r   <= start_cnt;
         ftext_r <= fixed_text;
         fkey_r  <= fixed_key;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         plainText  <= '0;
         cypher_key <= '0;
         vec_idx    <= '0;
         rep        <= '0;
         lfsr       <= LFSR_SEED;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         out_valid  <= valid_n;
         plainText  <= vec_n.text;
         cypher_key <= vec_n.key;
         vec_idx    <= idx_n;
         rep        <= rep_n;
         lfsr       <= lfsr_n;
         busy       <= busy_n;
         done       <= done_n;
      end
   end

   always_comb begin
      state_n    = state;
      valid_n    = out_valid;
      vec_n.text = plainText;
      vec_n.key  = cypher_key;
      idx_n      = vec_idx;
      rep_n      = rep;
      lfsr_n     = lfsr;
      busy_n     = busy;
      done_n     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               busy_n = 1'b1;
               lfsr_n = LFSR_SEED;
               rep_n  = '0;
               idx_n  = '0;
               if (start_cnt == '0) begin
                  state_n = FIN;
               end else begin
                  state_n = RUN;
                  valid_n = 1'b1;
                  vec_n   = gen_vec(mode, '0, LFSR_SEED, fixed_text, fixed_key);
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_n = IDLE;
               valid_n = 1'b0;
               busy_n  = 1'b0;
            end else if (out_valid && out_ready) begin
               if (rep != rep_max) begin
                  rep_n = rep + 1'b1;
               end else begin
                  rep_n = '0;
                  if (last) begin
                     state_n = FIN;
                     valid_n = 1'b0;
                  end else begin
                     idx_n  = vec_idx + 1'b1;
                     lfsr_n = lfsr_adv;
                     vec_n  = gen_vec(mode_r, vec_idx + 1'b1, lfsr_adv, ftext_r, fkey_r);
                  end
               end
            end
         end
         FIN: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_aes_vector_gen.sv
// tb/tb_aes_vector_gen.sv - self-checking bench for aes_vector_gen
// Two instances (128-bit and 256-bit key) checked against a vector-list reference model.
module tb_aes_vector_gen;
   localparam int CW = 16;
   localparam int RW = 8;

   logic            clk = 1'b0, reset = 1'b1, start = 1'b0, start_b = 1'b0, abort = 1'b0, out_ready = 1'b0;
   logic [1:0]      mode = '0;
   logic [RW-1:0]   repeat_cnt = '0;
   logic [CW-1:0]   num_vec = '0;
   logic [127:0]    fixed_text = '0, fixed_key = '0;
   logic [255:0]    fixed_key_b = '0;

   logic            valid_a, busy_a, done_a, valid_b, busy_b, done_b;
   logic [127:0]    text_a, key_a, text_b;
   logic [255:0]    key_b;
   logic [CW-1:0]   idx_a, idx_b;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   aes_vector_gen #(.KEY_SIZE(128), .REPEAT_W(RW), .CNT_W(CW), .LFSR_SEED(128'h1)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
      .repeat_cnt(repeat_cnt), .num_vec(num_vec), .fixed_text(fixed_text), .fixed_key(fixed_key),
      .out_ready(out_ready), .out_valid(valid_a), .plainText(text_a), .cypher_key(key_a),
      .vec_idx(idx_a), .busy(busy_a), .done(done_a));

   aes_vector_gen #(.KEY_SIZE(256), .REPEAT_W(RW), .CNT_W(CW), .LFSR_SEED(128'h1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .abort(abort), .mode(mode),
      .repeat_cnt(repeat_cnt), .num_vec(num_vec), .fixed_text(fixed_text), .fixed_key(fixed_key_b),
      .out_ready(out_ready), .out_valid(valid_b), .plainText(text_b), .cypher_key(key_b),
      .vec_idx(idx_b), .busy(busy_b), .done(done_b));

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // A key/text with the top n bits of a w-bit word set
   function automatic logic [255:0] top_ones(input int n, input int w);
      logic [255:0] r;
      r = '0;
      for (int b = 0; b < n; b++) r[w-1-b] = 1'b1;
      return r;
   endfunction

   task automatic sample(input bit b, output logic v, output logic [127:0] t, output logic [255:0] k,
                         output logic [CW-1:0] i, output logic bz, output logic dn);
      if (b) begin v = valid_b; t = text_b; k = key_b;         i = idx_b; bz = busy_b; dn = done_b; end
      else   begin v = valid_a; t = text_a; k = {128'd0, key_a}; i = idx_a; bz = busy_a; dn = done_a; end
   endtask

   task automatic run_check(input string tag, input bit b, input int ks, input logic [1:0] m,
                            input int nvec, input int reps, input bit rnd,
                            input logic [127:0] ft, input logic [255:0] fk);
      logic [127:0] et[$];
      logic [255:0] ek[$];
      logic [127:0] s, t, pt;
      logic [255:0] k, pk, tmp;
      logic [CW-1:0] i, pi;
      logic v, bz, dn, rdy, stalled;
      int total, xfer, cyc, vi;
      s = 128'h1;
      for (int n = 0; n < nvec; n++) begin
         case (m)
            2'd0: begin et.push_back('0); ek.push_back(top_ones(n + 1, ks)); end
            2'd1: begin tmp = top_ones(n + 1, 128); et.push_back(tmp[127:0]); ek.push_back('0); end
            2'd2: begin et.push_back(s); ek.push_back(fk); end
            default: begin et.push_back(ft); ek.push_back(fk); end
         endcase
         s = {s[126:0], s[127] ^ s[126] ^ s[125] ^ s[120]};
      end
      total = nvec * (reps + 1);
      @(negedge clk);
      mode = m; repeat_cnt = RW'(reps); fixed_text = ft; fixed_key = fk[127:0]; fixed_key_b = fk;
      num_vec = (m < 2'd2) ? CW'($urandom) : CW'(nvec);
      if (b) start_b = 1'b1; else start = 1'b1;
      @(negedge clk);
      start = 1'b0; start_b = 1'b0;
      xfer = 0; cyc = 0; stalled = 1'b0; pt = '0; pk = '0; pi = '0;
      while (xfer < total && cyc < 8 * total + 20) begin
         sample(b, v, t, k, i, bz, dn);
         chk({tag, " valid"}, v, 1'b1);
         chk({tag, " no_done"}, dn, 1'b0);
         if (stalled) chk({tag, " hold"}, {t, k, i}, {pt, pk, pi});
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         out_ready = rdy;
         if (rdy) begin
            vi = xfer / (reps + 1);
            chk({tag, " text"}, t, et[vi]);
            chk({tag, " key"}, k, ek[vi]);
            chk({tag, " idx"}, i, CW'(vi));
            xfer++;
         end
         stalled = !rdy; pt = t; pk = k; pi = i;
         cyc++;
         @(negedge clk);
      end
      chk({tag, " transfers"}, xfer, total);
      sample(b, v, t, k, i, bz, dn);
      chk({tag, " fin_valid"}, v, 1'b0);
      chk({tag, " fin_busy"}, bz, 1'b1);
      chk({tag, " fin_done"}, dn, 1'b0);
      @(negedge clk);
      sample(b, v, t, k, i, bz, dn);
      chk({tag, " done_pulse"}, dn, 1'b1);
      chk({tag, " done_busy"}, bz, 1'b0);
      chk({tag, " done_valid"}, v, 1'b0);
      @(negedge clk);
      sample(b, v, t, k, i, bz, dn);
      chk({tag, " done_once"}, dn, 1'b0);
   endtask

   initial begin
      logic [127:0] rt;
      logic [255:0] rk;
      int found;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {valid_a, text_a, key_a, idx_a, busy_a, done_a}, '0);
      reset = 1'b0;

      run_check("varkey128", 1'b0, 128, 2'd0, 128, 0, 1'b0, '0, '0);
      run_check("vartext_rep2", 1'b0, 128, 2'd1, 128, 2, 1'b0, '0, '0);
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_check("random4", 1'b0, 128, 2'd2, 4, 0, 1'b1, '0, {128'd0, rk[127:0]});
      run_check("random5_rep1", 1'b0, 128, 2'd2, 5, 1, 1'b1, '0, {128'd0, rk[255:128]});
      rt = {$urandom, $urandom, $urandom, $urandom};
      run_check("fixed_rand", 1'b0, 128, 2'd3, $urandom_range(1, 6), $urandom_range(0, 3), 1'b1, rt, {128'd0, rk[127:0]});
      run_check("fixed_zero", 1'b0, 128, 2'd3, 0, 0, 1'b0, rt, {128'd0, rk[127:0]});

      // Async reset in the middle of a VarKey run
      @(negedge clk);
      mode = 2'd0; repeat_cnt = '0; out_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 100 && found == 0; c++) begin
         if (idx_a == CW'(37)) found = 1; else @(negedge clk);
      end
      chk("reach_idx37", found, 1);
      #2 reset = 1'b1;
      #1 chk("async_reset", {valid_a, text_a, key_a, idx_a, busy_a, done_a}, '0);
      @(negedge clk);
      reset = 1'b0;

      // Abort during a VarText run while a transfer is also offered
      mode = 2'd1; out_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_valid", valid_a, 1'b0);
      chk("abort_busy", busy_a, 1'b0);
      chk("abort_done", done_a, 1'b0);
      @(negedge clk);
      chk("abort_no_done", done_a, 1'b0);

      run_check("restart_varkey", 1'b0, 128, 2'd0, 128, 0, 1'b1, '0, '0);
      run_check("varkey256", 1'b1, 256, 2'd0, 256, 0, 1'b0, '0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
